// File: rtl/antirrebote_dedos.sv
// antirrebote_dedos
//   Debouncer for the four finger sensors. The raw levels are brought into the
//   clk domain through a two-flop synchronizer. The whole 4-bit vector is then
//   debounced as a single value. A new vector reaches entrada only after it has
//   been seen unchanged at the synchronizer output for N_DEB consecutive cycles.
//
// Ports
//   clk        system clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   dedos_raw  [3:0] raw sensor levels (bit0=A .. bit3=D), asynchronous to clk
//   entrada    [3:0] debounced finger vector, same bit order
//   cambio     one-cycle pulse on the first cycle entrada shows a new value
//   estable    high while no evaluation is pending
module antirrebote_dedos #(
  parameter int N_DEB = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dedos_raw,
  output logic [3:0] entrada,
  output logic       cambio,
  output logic       estable
);

  localparam logic [15:0] CNT_MAX = 16'(N_DEB - 1);

  typedef enum logic {
    ESTABLE,
    EVALUANDO
  } state_t;

  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic [3:0]  cand;
  logic [15:0] cnt;
  state_t      state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 4'b0000;
      sync2   <= 4'b0000;
      cand    <= 4'b0000;
      cnt     <= 16'd0;
      entrada <= 4'b0000;
      cambio  <= 1'b0;
      state   <= ESTABLE;
    end else begin
      sync1  <= dedos_raw;
      sync2  <= sync1;
      cambio <= 1'b0;
      if (sync2 != cand) begin
        // Any difference from the candidate restarts the stability window,
        // whether or not an evaluation was already running.
        cand  <= sync2;
        cnt   <= 16'd0;
        state <= EVALUANDO;
      end else if (state == EVALUANDO) begin
        if (cnt == CNT_MAX) begin
          // Candidate survived the full window. A bounce that returned to the
          // current value completes silently with no pulse.
          entrada <= cand;
          cambio  <= (cand != entrada);
          cnt     <= 16'd0;
          state   <= ESTABLE;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

  assign estable = (state == ESTABLE);

endmodule

// File: tb/tb_antirrebote_dedos.sv
// Testbench for antirrebote_dedos with N_DEB = 4.
// The stimulus pushes each expected cambio pulse into a queue. Each entry holds
// the entrada value and the cycle on which the pulse is due. A separate monitor
// pops and compares an entry whenever cambio is seen high. Inline checks cover
// estable and entrada cycle by cycle, plus the reset behaviour.
module tb_antirrebote_dedos;

  localparam int N_DEB = 4;
  localparam int LAT   = N_DEB + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dedos_raw = 4'b0000;
  logic [3:0] entrada;
  logic       cambio;
  logic       estable;

  typedef struct {
    logic [3:0] ent;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  antirrebote_dedos #(.N_DEB(N_DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dedos_raw (dedos_raw),
    .entrada   (entrada),
    .cambio    (cambio),
    .estable   (estable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: every cambio pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && cambio) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_cambio @cyc %0d: got entrada %b expected no pulse", cyc, entrada);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("cambio @cyc %0d entrada=%b (expected %b @cyc %0d)", cyc, entrada, e.ent, e.cyc);
        chk("cambio_entrada", entrada, e.ent);
        chk_int("cambio_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic expect_change(input logic [3:0] v, input int e0);
    exp_t e;
    e.ent = v;
    e.cyc = e0 + LAT;
    q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int e0;

    // Power-up reset
    wait_cycles(3);
    chk("rst_entrada", entrada, 4'b0000);
    chk("rst_cambio", {3'b0, cambio}, 4'd0);
    chk("rst_estable", {3'b0, estable}, 4'd1);
    rst_n = 1'b1;
    wait_cycles(3);

    // Glitch: 0001 for one cycle, then back to 0000
    dedos_raw = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("glitch_estable", {3'b0, estable}, (k >= 3 && k <= N_DEB + 3) ? 4'd0 : 4'd1);
      chk("glitch_entrada", entrada, 4'b0000);
      if (k == 1) dedos_raw = 4'b0000;
    end

    // Clean step 0000 -> 0011
    dedos_raw = 4'b0011;
    e0 = cyc;
    expect_change(4'b0011, e0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("step_estable", {3'b0, estable}, (k >= 3 && k < LAT) ? 4'd0 : 4'd1);
      chk("step_entrada", entrada, (k >= LAT) ? 4'b0011 : 4'b0000);
    end

    // Bounce on bit2 every 2 cycles for 12 cycles, then settle at 0111
    for (int i = 0; i < 6; i++) begin
      dedos_raw = (i % 2 == 0) ? 4'b0111 : 4'b0011;
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        chk("bounce_entrada", entrada, 4'b0011);
      end
    end
    dedos_raw = 4'b0111;
    e0 = cyc;
    expect_change(4'b0111, e0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("settle_entrada", entrada, (k >= LAT) ? 4'b0111 : 4'b0011);
    end

    // Reset in the middle of an evaluation
    dedos_raw = 4'b1111;
    wait_cycles(4);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_entrada", entrada, 4'b0000);
    chk("midrst_estable", {3'b0, estable}, 4'd1);
    dedos_raw = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("postrst_entrada", entrada, 4'b0000);
      chk("postrst_estable", {3'b0, estable}, 4'd1);
    end

    // Full gesture: 1111 held 10 cycles
    dedos_raw = 4'b1111;
    e0 = cyc;
    expect_change(4'b1111, e0);
    wait_cycles(10);
    chk("gesture_entrada", entrada, 4'b1111);

    // Asynchronous reset between edges with 1010 applied
    dedos_raw = 4'b1010;
    e0 = cyc;
    expect_change(4'b1010, e0);
    wait_cycles(10);
    chk("pre_rst_entrada", entrada, 4'b1010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_entrada", entrada, 4'b0000);
    chk("async_rst_cambio", {3'b0, cambio}, 4'd0);
    chk("async_rst_estable", {3'b0, estable}, 4'd1);

    // Release with 1010 still applied: treated as a fresh change
    @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc;
    expect_change(4'b1010, e0);
    wait_cycles(10);
    chk("release_entrada", entrada, 4'b1010);

    wait_cycles(3);
    chk_int("pending_pulses", q.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/antirrebote_dedos.md
ANTIRREBOTE_DEDOS -- requirements
Module: antirrebote_dedos

Interface
REQ-001 Parameter N_DEB, default 16, meaning: consecutive stable clock cycles required before a new finger vector is accepted; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 dedos_raw  input  4  raw finger-sensor levels, asynchronous to clk; bit0=A, bit1=B, bit2=C, bit3=D.
REQ-005 entrada  output  4  debounced finger vector, same bit order; drives the finger decoder input directly.
REQ-006 cambio  output  1  one-cycle pulse coincident with the first cycle entrada shows a new value.
REQ-007 estable  output  1  high when no evaluation is pending (state ESTABLE).

Function
REQ-008 Each dedos_raw bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-009 Debounce SHALL operate on the whole 4-bit vector, not per bit.
REQ-010 Internal state: 4-bit candidate register cand, 16-bit counter cnt, FSM with states ESTABLE and EVALUANDO.
REQ-011 Any edge where sync2 != cand: cand <= sync2, cnt <= 0, state <= EVALUANDO; applies in both states (restart on glitch).
REQ-012 EVALUANDO, sync2 == cand, cnt < N_DEB-1: cnt <= cnt+1.
REQ-013 EVALUANDO, sync2 == cand, cnt == N_DEB-1: entrada <= cand, cambio <= (cand != entrada), cnt <= 0, state <= ESTABLE.
REQ-014 ESTABLE, sync2 == cand: cnt, cand, entrada hold; cambio <= 0.
REQ-015 cambio SHALL be 0 on every edge not covered by REQ-013; never high two consecutive cycles.
REQ-016 Latency: a raw change first sampled by sync1 on edge 1 and held SHALL appear on entrada after edge N_DEB+3.
REQ-017 Bounce returning to the current entrada value before acceptance: evaluation completes, entrada unchanged, cambio stays 0.
REQ-018 entrada SHALL never show an intermediate vector that was not held for N_DEB consecutive cycles at sync2.
REQ-019 estable = (state == ESTABLE), combinational from the state register.
REQ-020 cnt SHALL never exceed N_DEB-1; no wrap-around.

Reset
REQ-021 rst_n low SHALL immediately force sync1, sync2, cand, entrada = 4'b0000, cnt = 0, cambio = 0, state = ESTABLE (estable = 1), irrespective of clk.
REQ-022 Reset asserted mid-EVALUANDO SHALL discard the pending evaluation; no cambio pulse results after release.
REQ-023 After rst_n deasserts, a nonzero dedos_raw held steady SHALL be treated as a new change per REQ-011/REQ-016.

Verification (bench with N_DEB = 4)
REQ-024 Reset: drive dedos_raw=1010, pulse rst_n low between clock edges -> entrada=0000, cambio=0, estable=1 immediately, before next edge.
REQ-025 Clean step: dedos_raw 0000->0011 held -> estable falls after edge 3, entrada=0011 and cambio=1 after edge 7 only, estable=1 after edge 7.
REQ-026 Bounce: bit2 toggles every 2 cycles for 12 cycles from 0011, then settles at 0111 -> exactly one cambio, entrada goes 0011->0111 directly, N_DEB+3 edges after the final toggle.
REQ-027 Glitch: from entrada=0000, dedos_raw=0001 for one cycle then 0000 -> estable drops for N_DEB+1 cycles, entrada stays 0000, cambio never asserts.
REQ-028 Reset mid-evaluation: apply 1111, assert rst_n at edge 4, release, hold 0000 -> entrada=0000, no cambio for 20 cycles.
REQ-029 Full gesture: dedos_raw=1111 held 10 cycles -> entrada=1111 with single cambio; downstream finger decoder output reads 2'b11.
